// File: rtl/fifo_512x36_fwft.sv
// 512x36 first-word-fall-through FIFO around a dual-port block RAM.
// Port 0 writes pushed words, port 1 prefetches the head word.

module xil_mem_dp_512x36 (
    input  logic        clk0,
    input  logic        i_en0,
    input  logic [3:0]  i_wen0,
    input  logic [8:0]  i_adr0,
    input  logic [35:0] i_dat0,
    input  logic        clk1,
    input  logic        i_en1,
    input  logic [3:0]  i_wen1,
    input  logic [8:0]  i_adr1,
    output logic [35:0] o_dat1
);

    logic [35:0] mem [512];
    logic [8:0]  adr1_q;
    logic [8:0]  adr1_d;

    // Byte-lane write on port 0, one 9-bit lane per enable bit
    always_ff @(posedge clk0) begin
        if (i_en0) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wen0[b]) begin
                    mem[i_adr0][b*9 +: 9] <= i_dat0[b*9 +: 9];
                end
            end
        end
    end

    // Port 1 is used read-only here; the read address only moves on an enabled read
    always_comb begin
        adr1_d = adr1_q;
        if (i_en1 && (i_wen1 == 4'h0)) begin
            adr1_d = i_adr1;
        end
    end

    // Registered read address, read data follows the latched address
    always_ff @(posedge clk1) begin
        adr1_q <= adr1_d;
    end

    assign o_dat1 = mem[adr1_q];

endmodule

module fifo_512x36_fwft (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_en,
    input  logic [35:0] i_wr_data,
    output logic        o_full,
    input  logic        i_rd_en,
    output logic [35:0] o_rd_data,
    output logic        o_empty,
    output logic [9:0]  o_count
);

    logic [8:0]  wr_ptr_q, wr_ptr_d;
    logic [8:0]  rd_ptr_q, rd_ptr_d;
    logic [9:0]  pend_q, pend_d;
    logic        v_q, v_d;
    logic [9:0]  count_q, count_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;

    logic        push;
    logic        pop;
    logic        fetch;
    logic        mem_en0;
    logic [3:0]  mem_wen0;
    logic        mem_en1;

    // Next-state logic; the presented word keeps its slot reserved until popped,
    // so fullness comes from the word count rather than the unfetched count
    always_comb begin
        push     = i_wr_en & ~full_q;
        pop      = i_rd_en & v_q;
        fetch    = (pend_q != 10'd0) & (~v_q | pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pend_d   = pend_q;
        v_d      = v_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 9'd1;
        end
        if (fetch) begin
            rd_ptr_d = rd_ptr_q + 9'd1;
        end
        pend_d = pend_q + {9'd0, push} - {9'd0, fetch};
        if (fetch) begin
            v_d = 1'b1;
        end else if (pop) begin
            v_d = 1'b0;
        end
        if (push && !pop) begin
            count_d = count_q + 10'd1;
        end else if (pop && !push) begin
            count_d = count_q - 10'd1;
        end
        if (rst) begin
            wr_ptr_d = 9'd0;
            rd_ptr_d = 9'd0;
            pend_d   = 10'd0;
            v_d      = 1'b0;
            count_d  = 10'd0;
        end
        full_d  = (count_d == 10'd512);
        empty_d = ~v_d;
    end

    // Memory strobes; nothing reaches the RAM while reset is held
    always_comb begin
        mem_en0  = push & ~rst;
        mem_wen0 = mem_en0 ? 4'hF : 4'h0;
        mem_en1  = fetch & ~rst;
    end

    // State and flag registers
    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        pend_q   <= pend_d;
        v_q      <= v_d;
        count_q  <= count_d;
        full_q   <= full_d;
        empty_q  <= empty_d;
    end

    xil_mem_dp_512x36 u_mem (
        .clk0   (clk),
        .i_en0  (mem_en0),
        .i_wen0 (mem_wen0),
        .i_adr0 (wr_ptr_q),
        .i_dat0 (i_wr_data),
        .clk1   (clk),
        .i_en1  (mem_en1),
        .i_wen1 (4'h0),
        .i_adr1 (rd_ptr_q),
        .o_dat1 (o_rd_data)
    );

    assign o_full  = full_q;
    assign o_empty = empty_q;
    assign o_count = count_q;

endmodule

// File: doc/fifo_512x36_fwft.md
# fifo_512x36_fwft

Single-clock, first-word-fall-through FIFO, 512 words of 36 bits, built around one `xil_mem_dp_512x36` block RAM. Port 0 of the memory is the write side; port 1 is the prefetch/read side. It sits between a 36-bit producer (9-bit bytes: 8 data + 1 parity/flag) and a consumer that wants the head word visible without issuing a read first. It is the standard buffering stage in front of or behind the dual-port memory in the datapath.

## Interface
- No parameters: depth 512 and width 36 are fixed by the memory block.
- `clk`  in  1  sole clock; drives both `clk0` and `clk1` of the memory.
- `rst`  in  1  synchronous, active-high reset.
- `i_wr_en`  in  1  push request; accepted only when `o_full`=0.
- `i_wr_data`  in  36  push data; all four byte enables are asserted on an accepted push.
- `o_full`  out  1  registered; 1 when `o_count`==512.
- `i_rd_en`  in  1  pop request; accepted only when `o_empty`=0.
- `o_rd_data`  out  36  head word, driven directly from memory port 1; valid only while `o_empty`=0.
- `o_empty`  out  1  registered; 0 when the head word is presented.
- `o_count`  out  10  registered; words accepted and not yet popped, 0..512.

## Operation
- State:
  - `wr_ptr[8:0]`: next write address.
  - `rd_ptr[8:0]`: next fetch address.
  - `pend[9:0]`: words written but not yet fetched, equal to `wr_ptr`-`rd_ptr` plus the full-wrap case.
  - `v`: a fetched head is presented. `o_empty` = !`v`.
  - `o_count`.
- Push:
  - `push` = `i_wr_en` & !`o_full`.
  - On a push: memory port 0 `i_en0`=1, `i_wen0`=4'hF, `i_adr0`=`wr_ptr`; then `wr_ptr`++ (wraps 511→0) and `pend`++.
  - Port 0 is idle otherwise (`i_en0`=0).
- Pop:
  - `pop` = `i_rd_en` & `v`.
- Fetch:
  - `fetch` = (`pend`>0) & (!`v` | `pop`).
  - On a fetch: port 1 `i_en1`=1, `i_adr1`=`rd_ptr`, `i_wen1`=0; then `rd_ptr`++ (wraps) and `pend`--.
  - `i_en1`=0 otherwise, so the memory's registered read address holds and `o_rd_data` stays stable.
- `v` next state: 1 if `fetch`; else 0 if `pop`; else unchanged.
- `o_count` next: +1 on push only, -1 on pop only, unchanged on both or neither.
- `o_full` and `o_empty` are computed from next-state values, so there are no combinational paths from requests to flags.
- Slot reservation: the presented word's RAM location is not freed until it is popped. Full is therefore based on `o_count`, not `pend`. The writer can never overwrite the address latched on port 1 while `v`=1.
- Push and fetch never target the same address in the same cycle, because a fetch requires `pend`>0 from the previous state.
- Boundaries:
  - Push while full is ignored; the memory and pointers are untouched. This holds even if a pop occurs in the same cycle, because `o_full` is registered.
  - Pop while empty is ignored.
  - Push and pop in the same cycle at `o_count`=1 with `pend`=0: the head is popped, then `v`=0 for one cycle, then the new word appears.
  - Pointer wrap at 511→0 is seamless.
- Reset:
  - Pointers, `pend`, `v` and `o_count` clear to 0. `o_full`=0, `o_empty`=1.
  - `o_rd_data` is undefined after reset (the RAM is not initialised).
  - Reset mid-operation discards all contents. No memory write is issued in a cycle with `rst`=1.

## Timing
- Push-to-visible latency into an empty FIFO is 2 cycles:
  - Push is accepted at edge N.
  - Fetch is issued in cycle N+1.
  - `o_empty`=0 and data is valid after edge N+1.
- Back-to-back pops sustain one word per cycle while `pend`>0. Each pop issues a fetch in the same cycle, so the next head appears after the same edge.
- `o_count` and `o_full` update on the edge of the accepted push or pop.
- `o_empty` updates on the edge of the fetch or pop.
- Throughput is 1 push and 1 pop per cycle concurrently.

## Test plan
- Reset, then push 36'h1_2345_6789 at edge 0 → `o_empty` falls after edge 1 with `o_rd_data`=36'h1_2345_6789 and `o_count`=1; pop → `o_empty`=1 and `o_count`=0.
- Push 512 words with an incrementing pattern → `o_full`=1 after the 512th push, `o_count`=512. A 513th push plus a simultaneous pop → the push is dropped, `o_count`=511. Drain → data is in order 0..511 with no loss.
- Continuous push+pop for 2000 cycles at `o_count`≈3 → pointers wrap ≥3 times, data is in order, and `o_count` is constant.
- Hold `i_rd_en`=0 with `v`=1 while pushing 10 more words → `o_rd_data` stays unchanged throughout.
- Pop with `o_empty`=1, and push with `o_full`=1 → no state change, and `i_en0`/`i_en1` stay low.
- Assert `rst` mid-stream with `o_count`=200 → next cycle `o_count`=0, `o_empty`=1, `o_full`=0; a fresh push then reads back correctly.
